// File: rtl/ps2_led_cmd_sequencer.sv
// Host-side PS/2 "Set LEDs" sequencer: sends 0xED then the LED byte, handles ack/resend,
// timeouts and bounded full-transaction retries, and forwards unconsumed rx bytes as keys.
module ps2_led_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       led_busy,
    output logic       led_done,
    output logic       led_err,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       tx_fail,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       key_valid,
    output logic [7:0] key_byte
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RetryLast = RW'(MAX_RETRY);
    localparam logic [7:0]    CmdSetLed = 8'hED;
    localparam logic [7:0]    RspAck    = 8'hFA;
    localparam logic [7:0]    RspResend = 8'hFE;

    typedef enum logic [2:0] {
        StIdle,
        StSendEd,
        StWaitTxEd,
        StWaitAckEd,
        StSendLed,
        StWaitTxLed,
        StWaitAckLed
    } state_e;

    state_e        state_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]    led_q;

    logic in_wait_tx, in_wait_ack, tmo_hit, rx_ack, rx_rsd, retry_left, fail, forward;

    always_comb begin
        in_wait_tx  = (state_q == StWaitTxEd) || (state_q == StWaitTxLed);
        in_wait_ack = (state_q == StWaitAckEd) || (state_q == StWaitAckLed);
        tmo_hit     = (tmo_q == TmoLast);
        rx_ack      = rx_valid && (rx_byte == RspAck);
        rx_rsd      = rx_valid && (rx_byte == RspResend);
        retry_left  = (retry_q < RetryLast);
        // tx_fail beats tx_done; any rx byte beats the timeout; a resend with no retries left fails
        fail = (in_wait_tx && (tx_fail || (!tx_done && tmo_hit)))
            || (in_wait_ack && ((!rx_valid && tmo_hit) || (rx_rsd && !retry_left)));
        forward = rx_valid && !(in_wait_ack && (rx_ack || rx_rsd));
    end

    assign led_busy = (state_q != StIdle);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= StIdle;
            retry_q   <= '0;
            tmo_q     <= '0;
            led_q     <= '0;
            tx_start  <= 1'b0;
            tx_byte   <= '0;
            led_done  <= 1'b0;
            led_err   <= 1'b0;
            key_valid <= 1'b0;
            key_byte  <= '0;
        end else begin
            tx_start  <= 1'b0;
            led_done  <= 1'b0;
            led_err   <= 1'b0;
            key_valid <= forward;
            if (forward) begin
                key_byte <= rx_byte;
            end

            if (fail) begin
                if (retry_left) begin
                    retry_q  <= retry_q + RW'(1);
                    state_q  <= StSendEd;
                    tx_start <= 1'b1;
                    tx_byte  <= CmdSetLed;
                end else begin
                    state_q <= StIdle;
                    led_err <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (led_req) begin
                            led_q    <= led_val;
                            retry_q  <= '0;
                            state_q  <= StSendEd;
                            tx_start <= 1'b1;
                            tx_byte  <= CmdSetLed;
                        end
                    end
                    StSendEd: begin
                        state_q <= StWaitTxEd;
                        tmo_q   <= '0;
                    end
                    StSendLed: begin
                        state_q <= StWaitTxLed;
                        tmo_q   <= '0;
                    end
                    StWaitTxEd, StWaitTxLed: begin
                        if (tx_done) begin
                            state_q <= (state_q == StWaitTxEd) ? StWaitAckEd : StWaitAckLed;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    StWaitAckEd: begin
                        if (rx_ack) begin
                            state_q  <= StSendLed;
                            tx_start <= 1'b1;
                            tx_byte  <= {5'b0, led_q};
                        end else if (rx_rsd) begin
                            retry_q  <= retry_q + RW'(1);
                            state_q  <= StSendEd;
                            tx_start <= 1'b1;
                            tx_byte  <= CmdSetLed;
                        end else if (!tmo_hit) begin
                            // scancodes keep the timer running; it parks at the last count
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    StWaitAckLed: begin
                        if (rx_ack) begin
                            state_q  <= StIdle;
                            led_done <= 1'b1;
                        end else if (rx_rsd) begin
                            retry_q  <= retry_q + RW'(1);
                            state_q  <= StSendLed;
                            tx_start <= 1'b1;
                            tx_byte  <= {5'b0, led_q};
                        end else if (!tmo_hit) begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
